sdram_arbiter: RTL and testbench

//  Owns the SDRAM command/address/data pins and time-shares them between the init, auto-refresh,

---
 rtl/sdram_arbiter.sv | 124 ++++++++++++
 tb/tb_sdram_arbiter.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/sdram_arbiter.sv
// SDRAM pin owner: time-shares the command/data pins across init, refresh, write and read engines; pins registered (1 cycle).
// Backpressure: a pending request is held off (grant low) until the FSM returns to ARBIT; refresh wins, write/read round-robin.
module sdram_arbiter #(
  parameter int DW      = 16,
  parameter int AW      = 13,
  parameter int BAW     = 2,
  parameter int TIMEOUT = 1024
) (
  input  logic           sys_clk,
  input  logic           sys_rst,
  input  logic           init_end,
  input  logic [3:0]     init_cmd,
  input  logic [BAW-1:0] init_ba,
  input  logic [AW-1:0]  init_addr,
  input  logic           aref_req,
  input  logic           aref_end,
  input  logic [3:0]     aref_cmd,
  input  logic [BAW-1:0] aref_ba,
  input  logic [AW-1:0]  aref_addr,
  input  logic           wr_req,
  input  logic           wr_end,
  input  logic [3:0]     wr_cmd,
  input  logic [BAW-1:0] wr_ba,
  input  logic [AW-1:0]  wr_addr,
  input  logic           wr_sdram_en,
  input  logic [DW-1:0]  wr_sdram_data,
  input  logic           rd_req,
  input  logic           rd_end,
  input  logic [3:0]     rd_cmd,
  input  logic [BAW-1:0] rd_ba,
  input  logic [AW-1:0]  rd_addr,
  output logic           aref_en,
  output logic           wr_en,
  output logic           rd_en,
  output logic [3:0]     sdram_cmd,
  output logic [BAW-1:0] sdram_ba,
  output logic [AW-1:0]  sdram_addr,
  output logic [DW-1:0]  sdram_dq_o,
  output logic           sdram_dq_oe,
  output logic           timeout_err
);

  localparam int              WDW      = $clog2(TIMEOUT);
  localparam logic [WDW-1:0]  WDOG_MAX = WDW'(TIMEOUT - 1);
  localparam logic [3:0]      CMD_NOP  = 4'b0111;

  typedef enum logic [2:0] {S_INIT, S_ARBIT, S_AREF, S_WRITE, S_READ} state_t;

  state_t         state, state_nxt;
  logic           rr_last_rd;
  logic [WDW-1:0] wdog;
  logic           granted;
  logic           cur_end;
  logic           wdog_exp;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) state <= S_INIT;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_INIT:  if (init_end) state_nxt = S_ARBIT;
      S_ARBIT: begin
        if (aref_req)            state_nxt = S_AREF;
        else if (wr_req && rd_req) state_nxt = rr_last_rd ? S_WRITE : S_READ;
        else if (wr_req)         state_nxt = S_WRITE;
        else if (rd_req)         state_nxt = S_READ;
      end
      S_AREF, S_WRITE, S_READ: if (cur_end || wdog_exp) state_nxt = S_ARBIT;
      default: state_nxt = S_INIT;
    endcase
  end

  always_comb begin
    aref_en     = (state == S_AREF);
    wr_en       = (state == S_WRITE);
    rd_en       = (state == S_READ);
    granted     = aref_en || wr_en || rd_en;
    // only the owning engine's end pulse releases the grant
    cur_end     = (aref_en && aref_end) || (wr_en && wr_end) || (rd_en && rd_end);
    wdog_exp    = granted && (wdog == WDOG_MAX);
    timeout_err = wdog_exp && !cur_end;
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      rr_last_rd <= 1'b1;
      wdog       <= '0;
    end else begin
      if (state == S_ARBIT && state_nxt == S_WRITE) rr_last_rd <= 1'b0;
      if (state == S_ARBIT && state_nxt == S_READ)  rr_last_rd <= 1'b1;
      if (state_nxt != state)          wdog <= '0;
      else if (granted && wdog != '1)  wdog <= wdog + 1'b1;
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      sdram_cmd   <= CMD_NOP;
      sdram_ba    <= '1;
      sdram_addr  <= '1;
      sdram_dq_o  <= '0;
      sdram_dq_oe <= 1'b0;
    end else begin
      case (state)
        S_INIT:  begin sdram_cmd <= init_cmd; sdram_ba <= init_ba; sdram_addr <= init_addr; end
        S_AREF:  begin sdram_cmd <= aref_cmd; sdram_ba <= aref_ba; sdram_addr <= aref_addr; end
        S_WRITE: begin sdram_cmd <= wr_cmd;   sdram_ba <= wr_ba;   sdram_addr <= wr_addr;   end
        S_READ:  begin sdram_cmd <= rd_cmd;   sdram_ba <= rd_ba;   sdram_addr <= rd_addr;   end
        default: begin sdram_cmd <= CMD_NOP;  sdram_ba <= '1;      sdram_addr <= '1;        end
      endcase
      if (state == S_WRITE) begin
        sdram_dq_o  <= wr_sdram_data;
        sdram_dq_oe <= wr_sdram_en;
      end else begin
        sdram_dq_o  <= '0;
        sdram_dq_oe <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter (TIMEOUT=16): init, priority, round-robin, dq timing, watchdog, async reset.
module tb_sdram_arbiter;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        init_end = 1'b0;
  logic [3:0]  init_cmd = 4'b0010;
  logic [1:0]  init_ba = 2'd1;
  logic [12:0] init_addr = 13'h00AA;
  logic        aref_req = 1'b0, aref_end = 1'b0;
  logic [3:0]  aref_cmd = 4'b0001;
  logic [1:0]  aref_ba = 2'd2;
  logic [12:0] aref_addr = 13'h0400;
  logic        wr_req = 1'b0, wr_end = 1'b0;
  logic [3:0]  wr_cmd = 4'b0100;
  logic [1:0]  wr_ba = 2'd3;
  logic [12:0] wr_addr = 13'h0123;
  logic        wr_sdram_en = 1'b0;
  logic [15:0] wr_sdram_data = 16'h0000;
  logic        rd_req = 1'b0, rd_end = 1'b0;
  logic [3:0]  rd_cmd = 4'b0101;
  logic [1:0]  rd_ba = 2'd0;
  logic [12:0] rd_addr = 13'h0055;
  logic        aref_en, wr_en, rd_en;
  logic [3:0]  sdram_cmd;
  logic [1:0]  sdram_ba;
  logic [12:0] sdram_addr;
  logic [15:0] sdram_dq_o;
  logic        sdram_dq_oe;
  logic        timeout_err;

  int vectors = 0;
  int miscompares = 0;

  sdram_arbiter #(.DW(16), .AW(13), .BAW(2), .TIMEOUT(16)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .init_end(init_end), .init_cmd(init_cmd), .init_ba(init_ba), .init_addr(init_addr),
    .aref_req(aref_req), .aref_end(aref_end), .aref_cmd(aref_cmd), .aref_ba(aref_ba), .aref_addr(aref_addr),
    .wr_req(wr_req), .wr_end(wr_end), .wr_cmd(wr_cmd), .wr_ba(wr_ba), .wr_addr(wr_addr),
    .wr_sdram_en(wr_sdram_en), .wr_sdram_data(wr_sdram_data),
    .rd_req(rd_req), .rd_end(rd_end), .rd_cmd(rd_cmd), .rd_ba(rd_ba), .rd_addr(rd_addr),
    .aref_en(aref_en), .wr_en(wr_en), .rd_en(rd_en),
    .sdram_cmd(sdram_cmd), .sdram_ba(sdram_ba), .sdram_addr(sdram_addr),
    .sdram_dq_o(sdram_dq_o), .sdram_dq_oe(sdram_dq_oe), .timeout_err(timeout_err)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // grants packed as {aref_en, wr_en, rd_en}
  task automatic check_grants(input string tag, input logic [2:0] exp);
    check(tag, {29'd0, aref_en, wr_en, rd_en}, {29'd0, exp});
  endtask

  task automatic check_pins(input string tag, input logic [3:0] cmd, input logic [1:0] ba, input logic [12:0] addr);
    check({tag, "_cmd"}, {28'd0, sdram_cmd}, {28'd0, cmd});
    check({tag, "_ba"}, {30'd0, sdram_ba}, {30'd0, ba});
    check({tag, "_addr"}, {19'd0, sdram_addr}, {19'd0, addr});
  endtask

  initial begin
    // reset state
    @(negedge sys_clk);
    @(negedge sys_clk);
    check_pins("rst", 4'b0111, 2'b11, 13'h1FFF);
    check_grants("rst_grants", 3'b000);
    check("rst_dq_oe", {31'd0, sdram_dq_oe}, 32'd0);
    check("rst_dq_o", {16'd0, sdram_dq_o}, 32'd0);
    check("rst_terr", {31'd0, timeout_err}, 32'd0);

    // T1: init bus forwarded, requests held off in INIT
    sys_rst = 1'b0;
    wr_req  = 1'b1;
    @(negedge sys_clk);
    check_pins("t1_init", 4'b0010, 2'd1, 13'h00AA);
    check_grants("t1_held_off", 3'b000);
    wr_req   = 1'b0;
    init_end = 1'b1;
    @(negedge sys_clk);
    check_grants("t1_to_arbit", 3'b000);
    @(negedge sys_clk);
    check_pins("t1_arbit_nop", 4'b0111, 2'b11, 13'h1FFF);

    // T2: refresh beats write/read; then write wins first contest
    aref_req = 1'b1; wr_req = 1'b1; rd_req = 1'b1;
    @(negedge sys_clk);
    check_grants("t2_aref_first", 3'b100);
    aref_req = 1'b0;
    @(negedge sys_clk);
    check_pins("t2_aref_pins", 4'b0001, 2'd2, 13'h0400);
    aref_end = 1'b1;
    @(negedge sys_clk);
    check_grants("t2_gap_after_aref", 3'b000);
    aref_end = 1'b0;
    @(negedge sys_clk);
    check_grants("t2_wr_grant", 3'b010);
    check("t2_wr_first_nop", {28'd0, sdram_cmd}, 32'h7);

    // T3: 4 data cycles appear on dq one cycle late; read held off
    wr_sdram_en = 1'b1; wr_sdram_data = 16'hA5A5;
    for (int i = 0; i < 4; i++) begin
      @(negedge sys_clk);
      check("t3_dq_oe", {31'd0, sdram_dq_oe}, 32'd1);
      check("t3_dq_o", {16'd0, sdram_dq_o}, 32'h0000A5A5);
      check_grants("t3_rd_held", 3'b010);
      if (i == 0) check_pins("t3_wr_pins", 4'b0100, 2'd3, 13'h0123);
      if (i == 3) begin
        wr_sdram_en = 1'b0; wr_sdram_data = 16'h1234; wr_end = 1'b1;
      end
    end
    @(negedge sys_clk);
    wr_end = 1'b0;
    check("t3_dq_oe_off", {31'd0, sdram_dq_oe}, 32'd0);
    check("t3_dq_o_last", {16'd0, sdram_dq_o}, 32'h00001234);
    check_grants("t3_gap_after_wr", 3'b000);
    @(negedge sys_clk);
    check_grants("t2_rr_rd", 3'b001);
    check("t3_dq_o_cleared", {16'd0, sdram_dq_o}, 32'd0);

    // T5: foreign end pulse ignored during READ
    wr_req = 1'b0; wr_end = 1'b1;
    @(negedge sys_clk);
    check_grants("t5_wr_end_ignored", 3'b001);
    check_pins("t5_rd_pins", 4'b0101, 2'd0, 13'h0055);
    wr_end = 1'b0; rd_end = 1'b1;
    @(negedge sys_clk);
    check_grants("t5_rd_end", 3'b000);
    check("t5_no_terr", {31'd0, timeout_err}, 32'd0);
    rd_end = 1'b0;

    // T4: read never ends -> watchdog pulse on 16th grant cycle
    for (int k = 1; k <= 16; k++) begin
      @(negedge sys_clk);
      check_grants("t4_rd_held", 3'b001);
      check("t4_terr", {31'd0, timeout_err}, (k == 16) ? 32'd1 : 32'd0);
      if (k == 16) rd_req = 1'b0;
    end
    @(negedge sys_clk);
    check_grants("t4_after_timeout", 3'b000);
    check("t4_terr_cleared", {31'd0, timeout_err}, 32'd0);

    // T6: async reset mid-write
    wr_req = 1'b1; wr_sdram_en = 1'b1; wr_sdram_data = 16'hBEEF;
    @(negedge sys_clk);
    check_grants("t6_wr_grant", 3'b010);
    @(negedge sys_clk);
    check("t6_dq_oe_on", {31'd0, sdram_dq_oe}, 32'd1);
    #2;
    sys_rst  = 1'b1;
    init_end = 1'b0;
    #1;
    check_grants("t6_async_grants", 3'b000);
    check("t6_async_dq_oe", {31'd0, sdram_dq_oe}, 32'd0);
    check("t6_async_cmd", {28'd0, sdram_cmd}, 32'h7);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    @(negedge sys_clk);
    check_grants("t6_init_held", 3'b000);
    check("t6_init_cmd", {28'd0, sdram_cmd}, 32'h2);
    @(negedge sys_clk);
    check_grants("t6_still_init", 3'b000);
    init_end = 1'b1;
    @(negedge sys_clk);
    check_grants("t6_arbit", 3'b000);
    @(negedge sys_clk);
    check_grants("t6_wr_after_init", 3'b010);
    wr_req = 1'b0; wr_end = 1'b1; wr_sdram_en = 1'b0;
    @(negedge sys_clk);
    wr_end = 1'b0;
    check_grants("t6_wr_done", 3'b000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
